// File: rtl/imem_pkg.sv
// Shared state encoding, address/counter constants and helpers for imem_responder.
package imem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } imem_state_t;

  // Byte address to word index shift.
  localparam int IMEM_OFFSET_BITS = 2;

  localparam int IMEM_CNT_W = 8;
  typedef logic [IMEM_CNT_W-1:0] imem_cnt_t;

  function automatic logic [31:0] imem_sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/imem_storage_ram.sv
// Word storage with a synchronous preload write port and a registered read port.
// Read-before-write on same-address collisions; rd_clr loads zero without touching the array.
module imem_storage_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4096
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     rd_en,
  input  logic                     rd_clr,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Non-blocking update of mem means a same-edge read still sees the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_clr) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Fetch responder: samples mem_req in IDLE, answers LATENCY cycles later with a one-cycle mem_ready;
// requests are ignored while busy. Optional counters with IMEM_RESPONDER_STATS_EN.
module imem_responder
  import imem_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4096,
  parameter int                    LATENCY    = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mem_req,
  input  logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_data,
  output logic                     mem_ready,
  input  logic                     load_we,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0]    load_data,
  output logic                     busy,
  output logic                     oor_err
`ifdef IMEM_RESPONDER_STATS_EN
  ,
  output logic [31:0]              stat_reqs,
  output logic [31:0]              stat_busy_cycles
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam imem_cnt_t CNT_INIT = imem_cnt_t'(LATENCY - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_WORDS = (ADDR_WIDTH + 1)'(DEPTH);

  imem_state_t           state;
  imem_cnt_t             cnt;
  logic [IDX_W-1:0]      idx_q;
  logic                  oor_q;

  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] word;
  logic                  req_oor;
  logic [IDX_W-1:0]      req_idx;
  logic                  start;
  logic                  to_resp;
  logic [IDX_W-1:0]      rd_idx;
  logic                  rd_oor;

  // Range check on the live address; only used on the sampling edge.
  assign offset  = mem_addr - BASE_ADDR;
  assign word    = offset >> IMEM_OFFSET_BITS;
  assign req_oor = (mem_addr < BASE_ADDR) || ({1'b0, word} >= DEPTH_WORDS);
  assign req_idx = word[IDX_W-1:0];

  assign start   = (state == ST_IDLE) && mem_req;
  assign to_resp = (start && (LATENCY == 1)) ||
                   ((state == ST_WAIT) && (cnt == imem_cnt_t'(1)));

  // With LATENCY=1 the read happens on the sampling edge, before idx_q is valid.
  assign rd_idx = start ? req_idx : idx_q;
  assign rd_oor = start ? req_oor : oor_q;

  imem_storage_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (load_we),
    .wr_addr (load_addr),
    .wr_data (load_data),
    .rd_en   (to_resp && !rd_oor),
    .rd_clr  (to_resp && rd_oor),
    .rd_addr (rd_idx),
    .rd_data (mem_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      idx_q     <= '0;
      oor_q     <= 1'b0;
      mem_ready <= 1'b0;
      oor_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      mem_ready <= to_resp;
      oor_err   <= to_resp && rd_oor;
      case (state)
        ST_IDLE: begin
          if (mem_req) begin
            idx_q <= req_idx;
            oor_q <= req_oor;
            busy  <= 1'b1;
            if (LATENCY == 1) begin
              state <= ST_RESP;
              cnt   <= '0;
            end else begin
              state <= ST_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        ST_WAIT: begin
          cnt <= cnt - imem_cnt_t'(1);
          if (cnt == imem_cnt_t'(1)) begin
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef IMEM_RESPONDER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_reqs        <= '0;
      stat_busy_cycles <= '0;
    end else begin
      if (start) begin
        stat_reqs <= imem_sat_inc(stat_reqs);
      end
      if (busy) begin
        stat_busy_cycles <= imem_sat_inc(stat_busy_cycles);
      end
    end
  end
`else
  // Statistics counters compiled out.
`endif

endmodule

// File: doc/imem_responder.md
# imem_responder

Memory-side responder for the instruction-cache fetch interface. It samples a level-held `mem_req`/`mem_addr` from the cache miss path, waits a fixed, parameterised latency, then returns one word on `mem_data` with a one-cycle `mem_ready` pulse. It is backed by a word-addressed storage array that the bench or boot loader preloads through a separate write port. It sits between the icache and the SoC memory model in simulation and FPGA builds.

## Interface
- `ADDR_WIDTH`, default 32: byte address width of `mem_addr`.
- `DATA_WIDTH`, default 32: word width.
- `DEPTH`, default 4096: number of words stored. Must be a power of two.
- `LATENCY`, default 4: cycles from request sample to `mem_ready`. Legal range 1..255.
- `BASE_ADDR`, default 0: byte address of word 0. Must be word aligned.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `mem_req`  in  1  fetch request, held high by the requester until it sees `mem_ready`.
- `mem_addr`  in  ADDR_WIDTH  byte address; bits [1:0] are ignored.
- `mem_data`  out  DATA_WIDTH  read data; valid only while `mem_ready`=1.
- `mem_ready`  out  1  one-cycle response pulse.
- `load_we`  in  1  preload write strobe.
- `load_addr`  in  $clog2(DEPTH)  word index of the preload write.
- `load_data`  in  DATA_WIDTH  preload data.
- `busy`  out  1  high while a request is in flight (WAIT or RESP).
- `oor_err`  out  1  pulses with `mem_ready` when the address was out of range.

## Operation
- FSM states:
  - IDLE: sample `mem_req`. If it is 1, latch the word index `(mem_addr - BASE_ADDR) >> 2` and the out-of-range flag, and load the counter with LATENCY-1. Go to WAIT, or go directly to RESP when LATENCY=1.
  - WAIT: decrement the counter. When the counter is 0, go to RESP.
  - RESP: `mem_ready`=1 for exactly one cycle, then go to IDLE.
- Out of range: an address is out of range when `mem_addr` < BASE_ADDR or its index >= DEPTH. In that case `mem_data`=0 and `oor_err`=1 in the RESP cycle. The array is not read.
- Request commitment: a request is committed once sampled. If `mem_req` drops during WAIT, the response is still delivered. `mem_req` is ignored in WAIT and RESP, so there is no re-trigger during the requester's allocate cycle.
- Array read: the array is read at the clock edge entering RESP. The result is registered into `mem_data`.
- Preload port: `load_we` is accepted in any state. When a load and a read hit the same word on the same edge, the read returns the old data (read-before-write).
- Output hold: `mem_data` holds its last value outside RESP.

## Timing
- Reset values: `mem_ready`=0, `mem_data`=0, `busy`=0, `oor_err`=0, state=IDLE, counter=0. Array contents are not cleared.
- Latency: if `mem_req` is first high in cycle C0 (in IDLE), `mem_ready` is high in cycle C0+LATENCY only.
- Back-to-back requests: the earliest next request sample is the cycle after RESP. The minimum request-to-request spacing is therefore LATENCY+1 cycles.
- Outputs: all outputs are registered. There is no combinational path from `mem_req` to `mem_ready`.
- Reset mid-operation: asserting `rst_n` in WAIT or RESP drops `mem_ready` and `busy` immediately. The pending response is discarded.
- `busy`: high from cycle C0+1 through C0+LATENCY inclusive.

## Configuration
- `IMEM_RESPONDER_STATS_EN` defined: adds two output ports.
  - `stat_reqs`, 32 bits: accepted requests.
  - `stat_busy_cycles`, 32 bits: cycles with `busy`=1.
  - Both reset to 0 and saturate at 32'hFFFF_FFFF.
- Macro undefined: the ports and counters are absent. Functional behaviour is otherwise identical.

## Structure
- Package `imem_pkg`:
  - State enum (IDLE, WAIT, RESP).
  - `IMEM_OFFSET_BITS`=2.
  - Counter width constant (8 bits).
- Sub-module `imem_storage_ram`:
  - One synchronous write port (preload) and one synchronous read port.
  - Read-before-write on a same-address collision.
  - The FSM and the range check stay in the top module.

## Test plan
- Basic read: preload word 5 = 32'hDEADBEEF. Hold `mem_req`=1, `mem_addr`=32'h14 from cycle 0. Required: `mem_ready`=1 only in cycle 4, with `mem_data`=32'hDEADBEEF and `oor_err`=0.
- Minimum latency: LATENCY=1, address 0, word 0 = 32'h1. Required: `mem_ready` in cycle 1. A second request held from cycle 2 gets `mem_ready` in cycle 3.
- Out of range: DEPTH=4096, `mem_addr`=32'h0000_4000. Required: in cycle 4, `mem_ready`=1, `mem_data`=0, `oor_err`=1.
- Collision and abort:
  - A load to word 5 on the edge entering RESP returns the old value. The next read of word 5 returns the new value.
  - `mem_req` dropped in cycle 2 still yields `mem_ready` in cycle 4.
- Reset mid-flight: assert `rst_n`=0 in cycle 2 of a LATENCY=4 request. Required: `mem_ready` never pulses, `busy`=0, and a fresh request after reset completes normally.
- Stats: with `IMEM_RESPONDER_STATS_EN` defined, 3 requests at LATENCY=4. Required: `stat_reqs`=3 and `stat_busy_cycles`=12.
